// File: rtl/fetch_pc_unit.sv
// Program counter for the fetch stage: next-PC selection, alignment trap, retire counter.
// Two-state RUN/TRAP controller. A misaligned target freezes the PC until trap_clear.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imm_in,
  input  logic [31:0] alu_result,
  input  logic [1:0]  PCSel,
  input  logic        take_branch,
  input  logic        stall,
  input  logic        trap_clear,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_target,
  output logic [31:0] retired
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_TRAP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] trap_target_q, trap_target_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] seq_pc;
  logic [31:0] rel_pc;
  logic [31:0] target;
  logic        misaligned;

  // Target selection; the JALR LSB clear happens before the alignment check.
  always_comb begin
    seq_pc = pc_q + 32'd4;
    rel_pc = pc_q + imm_in;
    target = seq_pc;
    case (PCSel)
      2'b00:   target = seq_pc;
      2'b01:   target = take_branch ? rel_pc : seq_pc;
      2'b10:   target = alu_result & ~32'h0000_0001;
      default: target = rel_pc;
    endcase
    misaligned = (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      trap_pc_q     <= 32'h0;
      trap_target_q <= 32'h0;
      retired_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      trap_pc_q     <= trap_pc_d;
      trap_target_q <= trap_target_d;
      retired_q     <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (!stall && misaligned) state_d = S_TRAP;
      S_TRAP:  if (trap_clear) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Datapath updates; trap_clear in TRAP takes priority over stall.
  always_comb begin
    pc_d          = pc_q;
    trap_pc_d     = trap_pc_q;
    trap_target_d = trap_target_q;
    retired_d     = retired_q;
    case (state_q)
      S_RUN: begin
        if (!stall) begin
          if (misaligned) begin
            trap_pc_d     = pc_q;
            trap_target_d = target;
          end else begin
            pc_d      = target;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      S_TRAP: begin
        if (trap_clear) pc_d = TRAP_VEC;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc          = pc_q;
    pc_plus4    = seq_pc;
    trap        = (state_q == S_TRAP);
    trap_pc     = trap_pc_q;
    trap_target = trap_target_q;
    retired     = retired_q;
  end

endmodule
